rf_wport_arbiter: RTL and testbench

//  Shares the register file's single write port between the pipeline WB stage and the multi-cycle
//  MUL/DIV result stream. MUL/DIV results are buffered in a small FIFO. A 32-entry scoreboard

---
 rtl/rf_wport_arbiter_if.sv | 59 +++++
 rtl/rf_wport_arbiter.sv | 162 ++++++++++++++++
 tb/tb_rf_wport_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wport_arbiter_if.sv
// -----------------------------------------------------------------------------
// rf_wport_arbiter_if
// Purpose : Bundles the signals around the register-file write-port arbiter:
//           the WB-stage write request, the MUL/DIV result stream with its
//           ready handshake, the MUL/DIV issue notification, the ID-stage
//           source operands with the stall response, and the registered
//           write-port outputs towards the register file.
// Modports:
//   master - the pipeline side (WB, MUL/DIV, ID); drives requests and
//            observes ready/stall/hold and the register-file write port.
//   slave  - the arbiter itself.
// Signals :
//   wb_we/wb_addr/wb_data         WB write request
//   md_valid/md_ready/md_addr/md_data  MUL/DIV result handshake
//   md_issue/md_issue_rd          MUL/DIV issue, marks destination pending
//   rs_addr/rt_addr/stall         ID-stage hazard query
//   wb_hold                       one-cycle WB freeze request
//   rf_we/rf_waddr/rf_wdata       register-file write port
//   pend                          scoreboard bitmap (bit 0 always 0)
//   err                           sticky double-issue error
// -----------------------------------------------------------------------------
interface rf_wport_arbiter_if;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_issue;
    logic [4:0]  md_issue_rd;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        stall;
    logic        wb_hold;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pend;
    logic        err;

    modport master (
        output wb_we, wb_addr, wb_data,
        output md_valid, md_addr, md_data,
        output md_issue, md_issue_rd,
        output rs_addr, rt_addr,
        input  md_ready, stall, wb_hold,
        input  rf_we, rf_waddr, rf_wdata, pend, err
    );

    modport slave (
        input  wb_we, wb_addr, wb_data,
        input  md_valid, md_addr, md_data,
        input  md_issue, md_issue_rd,
        input  rs_addr, rt_addr,
        output md_ready, stall, wb_hold,
        output rf_we, rf_waddr, rf_wdata, pend, err
    );
endinterface

// File: rtl/rf_wport_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wport_arbiter
// Purpose : Shares the register file's single write port between the WB stage
//           and the multi-cycle MUL/DIV result stream. MUL/DIV results are
//           queued in a DEPTH-entry FIFO; WB normally wins, the FIFO drains in
//           idle WB cycles, and a starved FIFO head forces a one-cycle wb_hold
//           during which the head is written. A 32-bit scoreboard tracks
//           MUL/DIV destinations not yet written and produces the ID stall.
// Ports   :
//   clk    - clock, all state updates on posedge
//   rst_n  - asynchronous active-low reset
//   bus    - rf_wport_arbiter_if.slave (see interface header for signals)
// Params  :
//   DEPTH  - FIFO entries (>=1)
//   STARVE - blocked cycles of the FIFO head before wb_hold is raised (>=1)
// -----------------------------------------------------------------------------
module rf_wport_arbiter #(
    parameter int DEPTH  = 2,
    parameter int STARVE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    rf_wport_arbiter_if.slave  bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(STARVE) + 1;

    // FIFO storage carries data only; validity is tracked by count.
    logic [4:0]    fifoAddr [DEPTH];
    logic [31:0]   fifoData [DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [CW-1:0] count;
    logic [AW-1:0] age;

    logic          wbHold;
    logic          rfWe;
    logic [4:0]    rfWaddr;
    logic [31:0]   rfWdata;
    logic [31:0]   pend;
    logic          err;

    logic          notEmpty;
    logic          mdReady;
    logic          wbLive;
    logic          popNow;
    logic          pushNow;
    logic          starveNow;
    logic          issueErr;
    logic [4:0]    headAddr;
    logic [31:0]   headData;
    logic [31:0]   pendSet;
    logic [31:0]   pendClr;
    logic [31:0]   pendNext;

    function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        notEmpty = (count != '0);
        mdReady  = (count < CW'(DEPTH));
        headAddr = fifoAddr[rdPtr];
        headData = fifoData[rdPtr];
        // A WB write to r0 is a no-op, so it does not occupy the port.
        wbLive   = bus.wb_we && (bus.wb_addr != 5'd0);
        popNow   = notEmpty && (wbHold || !wbLive);
        pushNow  = bus.md_valid && mdReady;
        // wbHold guarantees a pop next cycle, so it can never repeat back-to-back.
        starveNow = notEmpty && !popNow && (age >= AW'(STARVE - 1)) && !wbHold;

        pendClr = '0;
        if (popNow) begin
            pendClr = 32'd1 << headAddr;
        end
        pendSet = '0;
        if (bus.md_issue && (bus.md_issue_rd != 5'd0)) begin
            pendSet = 32'd1 << bus.md_issue_rd;
        end
        // Set wins over a same-cycle clear; bit 0 is never tracked.
        pendNext = ((pend & ~pendClr) | pendSet) & ~32'd1;
        issueErr = |(pendSet & pend & ~pendClr);
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (pushNow) begin
            fifoAddr[wrPtr] <= bus.md_addr;
            fifoData[wrPtr] <= bus.md_data;
        end
    end

    // FIFO control, starvation age and hold request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr  <= '0;
            wrPtr  <= '0;
            count  <= '0;
            age    <= '0;
            wbHold <= 1'b0;
        end else begin
            if (pushNow) begin
                wrPtr <= ptrInc(wrPtr);
            end
            if (popNow) begin
                rdPtr <= ptrInc(rdPtr);
            end
            case ({pushNow, popNow})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (popNow) begin
                age <= '0;
            end else if (notEmpty && (age != '1)) begin
                age <= age + 1'b1;
            end
            wbHold <= starveNow;
        end
    end

    // Write-port register and scoreboard
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rfWe    <= 1'b0;
            rfWaddr <= '0;
            rfWdata <= '0;
            pend    <= '0;
            err     <= 1'b0;
        end else begin
            if (popNow) begin
                // An r0 entry still drains, but must not write.
                rfWe    <= (headAddr != 5'd0);
                rfWaddr <= headAddr;
                rfWdata <= headData;
            end else if (wbLive) begin
                rfWe    <= 1'b1;
                rfWaddr <= bus.wb_addr;
                rfWdata <= bus.wb_data;
            end else begin
                rfWe    <= 1'b0;
            end
            pend <= pendNext;
            if (issueErr) begin
                err <= 1'b1;
            end
        end
    end

    assign bus.md_ready = mdReady;
    assign bus.stall    = ((bus.rs_addr != 5'd0) && pend[bus.rs_addr]) ||
                          ((bus.rt_addr != 5'd0) && pend[bus.rt_addr]);
    assign bus.wb_hold  = wbHold;
    assign bus.rf_we    = rfWe;
    assign bus.rf_waddr = rfWaddr;
    assign bus.rf_wdata = rfWdata;
    assign bus.pend     = pend;
    assign bus.err      = err;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
module tb_rf_wport_arbiter;

    localparam int DEPTH  = 2;
    localparam int STARVE = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_wport_arbiter_if bus();

    rf_wport_arbiter #(.DEPTH(DEPTH), .STARVE(STARVE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int nCmp = 0;
    int nBad = 0;

    // Reference model: FIFO as a queue, scoreboard as a bitmap.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mPend;
    logic        mErr;
    logic        mHold;
    logic        mRfWe;
    logic [4:0]  mRfA;
    logic [31:0] mRfD;
    int          mAge;
    bit          mAcc;

    logic [31:0] regFile [32];

    always @(negedge clk) begin
        if (rst_n && bus.rf_we) regFile[bus.rf_waddr] = bus.rf_wdata;
    end

    task automatic modelReset();
        mq.delete();
        mPend = '0; mErr = 0; mHold = 0; mRfWe = 0; mRfA = '0; mRfD = '0; mAge = 0; mAcc = 0;
    endtask

    task automatic modelStep();
        bit wbLive;
        bit popping;
        bit newHold;
        int sz;
        ent_t h;
        logic [31:0] clr;
        logic [31:0] set;
        clr = '0; set = '0;
        wbLive  = bus.wb_we && (bus.wb_addr != 0);
        sz      = mq.size();
        popping = (sz > 0) && (mHold || !wbLive);
        mAcc    = bus.md_valid && (sz < DEPTH);
        if (popping) begin
            h = mq.pop_front();
            clr[h.a] = 1'b1;
            mRfWe = (h.a != 0); mRfA = h.a; mRfD = h.d;
        end else if (wbLive) begin
            mRfWe = 1'b1; mRfA = bus.wb_addr; mRfD = bus.wb_data;
        end else begin
            mRfWe = 1'b0;
        end
        if (bus.md_issue && bus.md_issue_rd != 0) begin
            if (mPend[bus.md_issue_rd] && !clr[bus.md_issue_rd]) mErr = 1'b1;
            set[bus.md_issue_rd] = 1'b1;
        end
        mPend   = (mPend & ~clr) | set;
        newHold = (sz > 0) && !popping && (mAge >= STARVE - 1) && !mHold;
        mAge    = popping ? 0 : ((sz > 0) ? mAge + 1 : mAge);
        if (mAcc) mq.push_back('{bus.md_addr, bus.md_data});
        mHold   = newHold;
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic setIdle();
        bus.wb_we = 0; bus.wb_addr = '0; bus.wb_data = '0;
        bus.md_valid = 0; bus.md_addr = '0; bus.md_data = '0;
        bus.md_issue = 0; bus.md_issue_rd = '0;
        bus.rs_addr = '0; bus.rt_addr = '0;
    endtask

    task automatic test_reset();
        setIdle();
        rst_n = 0;
        #12;
        nCmp++; if (bus.rf_we !== 1'b0) begin nBad++; $display("FAIL por_rf_we got=%b want=0", bus.rf_we); end
        nCmp++; if (bus.pend !== 32'h0) begin nBad++; $display("FAIL por_pend got=%h want=0", bus.pend); end
        nCmp++; if (bus.md_ready !== 1'b1) begin nBad++; $display("FAIL por_md_ready got=%b want=1", bus.md_ready); end
        @(negedge clk);
        rst_n = 1;
        modelReset();
        tick();
        // two FIFO entries blocked behind WB writes, pend[5] set
        bus.md_issue = 1; bus.md_issue_rd = 5'd5;
        bus.md_valid = 1; bus.md_addr = 5'd5; bus.md_data = 32'h1;
        bus.wb_we = 1; bus.wb_addr = 5'd1; bus.wb_data = 32'hAA;
        tick();
        bus.md_issue = 0;
        bus.md_addr = 5'd6; bus.md_data = 32'h2;
        tick();
        nCmp++; if (bus.pend !== 32'h20) begin nBad++; $display("FAIL pre_rst_pend got=%h want=00000020", bus.pend); end
        nCmp++; if (bus.md_ready !== 1'b0) begin nBad++; $display("FAIL pre_rst_full got=%b want=0", bus.md_ready); end
        nCmp++; if (bus.rf_waddr !== 5'd1) begin nBad++; $display("FAIL pre_rst_waddr got=%0d want=1", bus.rf_waddr); end
        #2;
        rst_n = 0;
        #1;
        nCmp++; if (bus.rf_we !== 1'b0) begin nBad++; $display("FAIL rst_rf_we got=%b want=0", bus.rf_we); end
        nCmp++; if (bus.rf_waddr !== 5'd0) begin nBad++; $display("FAIL rst_rf_waddr got=%0d want=0", bus.rf_waddr); end
        nCmp++; if (bus.rf_wdata !== 32'h0) begin nBad++; $display("FAIL rst_rf_wdata got=%h want=0", bus.rf_wdata); end
        nCmp++; if (bus.wb_hold !== 1'b0) begin nBad++; $display("FAIL rst_wb_hold got=%b want=0", bus.wb_hold); end
        nCmp++; if (bus.pend !== 32'h0) begin nBad++; $display("FAIL rst_pend got=%h want=0", bus.pend); end
        nCmp++; if (bus.err !== 1'b0) begin nBad++; $display("FAIL rst_err got=%b want=0", bus.err); end
        nCmp++; if (bus.md_ready !== 1'b1) begin nBad++; $display("FAIL rst_md_ready got=%b want=1", bus.md_ready); end
        setIdle();
        @(negedge clk);
        rst_n = 1;
        modelReset();
        tick();
        nCmp++; if (bus.rf_we !== 1'b0) begin nBad++; $display("FAIL post_rst_drained got=%b want=0", bus.rf_we); end
    endtask

    task automatic test_wb_only();
        bus.wb_we = 1; bus.wb_addr = 5'd3; bus.wb_data = 32'hDEADBEEF;
        tick();
        nCmp++; if (bus.rf_we !== 1'b1) begin nBad++; $display("FAIL wb_rf_we got=%b want=1", bus.rf_we); end
        nCmp++; if (bus.rf_waddr !== 5'd3) begin nBad++; $display("FAIL wb_waddr got=%0d want=3", bus.rf_waddr); end
        nCmp++; if (bus.rf_wdata !== 32'hDEADBEEF) begin nBad++; $display("FAIL wb_wdata got=%h want=deadbeef", bus.rf_wdata); end
        setIdle();
        @(negedge clk);
        #1;
        nCmp++; if (regFile[3] !== 32'hDEADBEEF) begin nBad++; $display("FAIL wb_reg3 got=%h want=deadbeef", regFile[3]); end
        tick();
        nCmp++; if (bus.rf_we !== 1'b0) begin nBad++; $display("FAIL wb_idle_we got=%b want=0", bus.rf_we); end
    endtask

    task automatic test_collision();
        bus.md_issue = 1; bus.md_issue_rd = 5'd7;
        tick();
        setIdle();
        bus.wb_we = 1; bus.wb_addr = 5'd4; bus.wb_data = 32'h11;
        bus.md_valid = 1; bus.md_addr = 5'd7; bus.md_data = 32'h22;
        tick();
        nCmp++; if (bus.rf_waddr !== 5'd4 || bus.rf_wdata !== 32'h11) begin nBad++; $display("FAIL col_first got=%0d/%h want=4/11", bus.rf_waddr, bus.rf_wdata); end
        nCmp++; if (bus.pend[7] !== 1'b1) begin nBad++; $display("FAIL col_pend_set got=%b want=1", bus.pend[7]); end
        setIdle();
        tick();
        nCmp++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7 || bus.rf_wdata !== 32'h22) begin nBad++; $display("FAIL col_second got=%b/%0d/%h want=1/7/22", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        nCmp++; if (bus.pend[7] !== 1'b0) begin nBad++; $display("FAIL col_pend_clr got=%b want=0", bus.pend[7]); end
        @(negedge clk);
        #1;
        nCmp++; if (regFile[4] !== 32'h11 || regFile[7] !== 32'h22) begin nBad++; $display("FAIL col_regs got=%h/%h want=11/22", regFile[4], regFile[7]); end
    endtask

    task automatic test_starvation();
        bus.md_valid = 1; bus.md_addr = 5'd9; bus.md_data = 32'h99;
        bus.wb_we = 1; bus.wb_addr = 5'd2; bus.wb_data = 32'h200;
        tick();
        bus.md_valid = 0;
        for (int i = 1; i <= 4; i++) begin
            bus.wb_addr = 5'(i + 2); bus.wb_data = 32'(i);
            tick();
            nCmp++; if (bus.wb_hold !== (i == 4)) begin nBad++; $display("FAIL starve_hold_%0d got=%b want=%b", i, bus.wb_hold, (i == 4)); end
            nCmp++; if (bus.rf_waddr !== 5'(i + 2)) begin nBad++; $display("FAIL starve_wb_%0d got=%0d want=%0d", i, bus.rf_waddr, i + 2); end
        end
        bus.wb_addr = 5'd20; bus.wb_data = 32'h55;
        tick();
        nCmp++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd9 || bus.rf_wdata !== 32'h99) begin nBad++; $display("FAIL starve_pop got=%b/%0d/%h want=1/9/99", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        nCmp++; if (bus.wb_hold !== 1'b0) begin nBad++; $display("FAIL starve_hold_drop got=%b want=0", bus.wb_hold); end
        tick();
        nCmp++; if (bus.rf_waddr !== 5'd20 || bus.rf_wdata !== 32'h55) begin nBad++; $display("FAIL starve_resume got=%0d/%h want=20/55", bus.rf_waddr, bus.rf_wdata); end
        setIdle();
        tick();
    endtask

    task automatic test_hazard();
        bus.md_issue = 1; bus.md_issue_rd = 5'd10;
        tick();
        bus.md_issue = 0;
        bus.rs_addr = 5'd10; bus.rt_addr = 5'd0;
        #1;
        nCmp++; if (bus.stall !== 1'b1) begin nBad++; $display("FAIL haz_rs got=%b want=1", bus.stall); end
        bus.rs_addr = 5'd0; bus.rt_addr = 5'd10;
        #1;
        nCmp++; if (bus.stall !== 1'b1) begin nBad++; $display("FAIL haz_rt got=%b want=1", bus.stall); end
        bus.rs_addr = 5'd0; bus.rt_addr = 5'd0;
        #1;
        nCmp++; if (bus.stall !== 1'b0) begin nBad++; $display("FAIL haz_r0 got=%b want=0", bus.stall); end
        bus.rs_addr = 5'd11;
        #1;
        nCmp++; if (bus.stall !== 1'b0) begin nBad++; $display("FAIL haz_other got=%b want=0", bus.stall); end
        bus.rs_addr = 5'd10;
        bus.md_valid = 1; bus.md_addr = 5'd10; bus.md_data = 32'hA0;
        tick();
        nCmp++; if (bus.stall !== 1'b1) begin nBad++; $display("FAIL haz_queued got=%b want=1", bus.stall); end
        bus.md_valid = 0;
        tick();
        nCmp++; if (bus.stall !== 1'b0 || bus.rf_waddr !== 5'd10) begin nBad++; $display("FAIL haz_popped got=%b/%0d want=0/10", bus.stall, bus.rf_waddr); end
        setIdle();
    endtask

    task automatic test_full_err();
        bus.wb_we = 1; bus.wb_addr = 5'd1; bus.wb_data = 32'h1;
        bus.md_valid = 1; bus.md_addr = 5'd11; bus.md_data = 32'hB;
        tick();
        bus.md_addr = 5'd12; bus.md_data = 32'hC;
        tick();
        bus.md_addr = 5'd13; bus.md_data = 32'hD;
        #1;
        nCmp++; if (bus.md_ready !== 1'b0) begin nBad++; $display("FAIL full_ready got=%b want=0", bus.md_ready); end
        tick();
        nCmp++; if (bus.rf_waddr !== 5'd1) begin nBad++; $display("FAIL full_wb got=%0d want=1", bus.rf_waddr); end
        bus.wb_we = 0;
        #1;
        nCmp++; if (bus.md_ready !== 1'b0) begin nBad++; $display("FAIL full_still got=%b want=0", bus.md_ready); end
        tick();
        nCmp++; if (bus.rf_waddr !== 5'd11 || bus.rf_wdata !== 32'hB) begin nBad++; $display("FAIL full_pop11 got=%0d/%h want=11/b", bus.rf_waddr, bus.rf_wdata); end
        nCmp++; if (bus.md_ready !== 1'b1) begin nBad++; $display("FAIL full_reopen got=%b want=1", bus.md_ready); end
        tick();
        nCmp++; if (bus.rf_waddr !== 5'd12) begin nBad++; $display("FAIL full_pop12 got=%0d want=12", bus.rf_waddr); end
        bus.md_valid = 0;
        tick();
        nCmp++; if (bus.rf_waddr !== 5'd13 || bus.rf_wdata !== 32'hD) begin nBad++; $display("FAIL full_pop13 got=%0d/%h want=13/d", bus.rf_waddr, bus.rf_wdata); end
        tick();
        nCmp++; if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd13) begin nBad++; $display("FAIL full_hold got=%b/%0d want=0/13", bus.rf_we, bus.rf_waddr); end
        bus.md_issue = 1; bus.md_issue_rd = 5'd10;
        tick();
        nCmp++; if (bus.err !== 1'b0) begin nBad++; $display("FAIL err_first got=%b want=0", bus.err); end
        tick();
        nCmp++; if (bus.err !== 1'b1 || bus.pend[10] !== 1'b1) begin nBad++; $display("FAIL err_reissue got=%b/%b want=1/1", bus.err, bus.pend[10]); end
        bus.md_issue = 0;
        tick();
        nCmp++; if (bus.err !== 1'b1) begin nBad++; $display("FAIL err_sticky got=%b want=1", bus.err); end
        setIdle();
    endtask

    task automatic test_random();
        bit mdV;
        mdV = 0;
        setIdle();
        rst_n = 0;
        #1;
        modelReset();
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 3000; c++) begin
            if (!mdV && ($urandom % 3 == 0)) begin
                mdV = 1;
                bus.md_addr = 5'($urandom % 16);
                bus.md_data = $urandom;
            end
            bus.md_valid    = mdV;
            bus.wb_we       = ($urandom % 3 != 0);
            bus.wb_addr     = 5'($urandom);
            bus.wb_data     = $urandom;
            bus.md_issue    = ($urandom % 5 == 0);
            bus.md_issue_rd = 5'($urandom % 16);
            bus.rs_addr     = 5'($urandom % 16);
            bus.rt_addr     = 5'($urandom % 16);
            #1;
            nCmp++; if (bus.md_ready !== (mq.size() < DEPTH)) begin nBad++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, bus.md_ready, (mq.size() < DEPTH)); end
            nCmp++; if (bus.stall !== ((bus.rs_addr != 0 && mPend[bus.rs_addr]) || (bus.rt_addr != 0 && mPend[bus.rt_addr]))) begin nBad++; $display("FAIL rnd_stall c=%0d got=%b", c, bus.stall); end
            if (c % 700 == 699) begin
                #1;
                rst_n = 0;
                #1;
                nCmp++; if (bus.pend !== 32'h0 || bus.rf_we !== 1'b0 || bus.err !== 1'b0) begin nBad++; $display("FAIL rnd_rst c=%0d got=%h/%b/%b want=0/0/0", c, bus.pend, bus.rf_we, bus.err); end
                modelReset();
                mdV = 0;
                bus.md_valid = 0;
                @(negedge clk);
                rst_n = 1;
                continue;
            end
            tick();
            if (mAcc) mdV = 0;
            nCmp++; if (bus.rf_we !== mRfWe) begin nBad++; $display("FAIL rnd_rf_we c=%0d got=%b want=%b", c, bus.rf_we, mRfWe); end
            nCmp++; if (bus.rf_waddr !== mRfA || bus.rf_wdata !== mRfD) begin nBad++; $display("FAIL rnd_rf_wbus c=%0d got=%0d/%h want=%0d/%h", c, bus.rf_waddr, bus.rf_wdata, mRfA, mRfD); end
            nCmp++; if (bus.wb_hold !== mHold) begin nBad++; $display("FAIL rnd_hold c=%0d got=%b want=%b", c, bus.wb_hold, mHold); end
            nCmp++; if (bus.pend !== mPend) begin nBad++; $display("FAIL rnd_pend c=%0d got=%h want=%h", c, bus.pend, mPend); end
            nCmp++; if (bus.err !== mErr) begin nBad++; $display("FAIL rnd_err c=%0d got=%b want=%b", c, bus.err, mErr); end
        end
        setIdle();
    endtask

    initial begin
        for (int r = 0; r < 32; r++) regFile[r] = '0;
        modelReset();
        test_reset();
        test_wb_only();
        test_collision();
        test_starvation();
        test_hazard();
        test_full_err();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
